// File: rtl/rvfi_retire_buffer.sv
// Retirement-record FIFO that feeds the single-channel RVFI trace, sanitising records on entry.
// Optional RVFI_RETIRE_INTR_EN derives rvfi_intr from the previous emitted record's trap/next-PC.
module rvfi_retire_buffer #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ILEN-1:0]   in_insn,
  input  logic              in_trap,
  input  logic              in_halt,
  input  logic [4:0]        in_rs1_addr,
  input  logic [4:0]        in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_rdata,
  input  logic [XLEN-1:0]   in_rs2_rdata,
  input  logic [4:0]        in_rd_addr,
  input  logic [XLEN-1:0]   in_rd_wdata,
  input  logic [XLEN-1:0]   in_pc_rdata,
  input  logic [XLEN-1:0]   in_pc_wdata,
  input  logic [XLEN-1:0]   in_mem_addr,
  input  logic [XLEN/8-1:0] in_mem_rmask,
  input  logic [XLEN/8-1:0] in_mem_wmask,
  input  logic [XLEN-1:0]   in_mem_rdata,
  input  logic [XLEN-1:0]   in_mem_wdata,
  output logic              rvfi_valid,
  output logic [63:0]       rvfi_order,
  output logic [ILEN-1:0]   rvfi_insn,
  output logic              rvfi_trap,
  output logic              rvfi_halt,
  output logic              rvfi_intr,
  output logic [4:0]        rvfi_rs1_addr,
  output logic [4:0]        rvfi_rs2_addr,
  output logic [XLEN-1:0]   rvfi_rs1_rdata,
  output logic [XLEN-1:0]   rvfi_rs2_rdata,
  output logic [4:0]        rvfi_rd_addr,
  output logic [XLEN-1:0]   rvfi_rd_wdata,
  output logic [XLEN-1:0]   rvfi_pc_rdata,
  output logic [XLEN-1:0]   rvfi_pc_wdata,
  output logic [XLEN-1:0]   rvfi_mem_addr,
  output logic [XLEN/8-1:0] rvfi_mem_rmask,
  output logic [XLEN/8-1:0] rvfi_mem_wmask,
  output logic [XLEN-1:0]   rvfi_mem_rdata,
  output logic [XLEN-1:0]   rvfi_mem_wdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [ILEN-1:0]   insn;
    logic              trap;
    logic              halt;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   rd_wdata;
    logic [XLEN-1:0]   pc_rdata;
    logic [XLEN-1:0]   pc_wdata;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_rmask;
    logic [XLEN/8-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
  } rec_t;

  rec_t            fifo_mem [DEPTH];
  rec_t            in_rec;
  rec_t            head;
  rec_t            out_q, out_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            halted_q, halted_d;
  logic [63:0]     order_q, order_d;
  logic [63:0]     out_order_q, out_order_d;
  logic            valid_q, valid_d;
  logic            intr_q, intr_d;
  logic            full, empty, push, pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign in_ready = !full && !halted_q;
  assign push     = in_valid && in_ready;
  assign pop      = !empty;
  assign head     = fifo_mem[rd_ptr_q];

  // Records are cleaned before storage so the FIFO only ever holds RVFI-legal entries.
  always_comb begin
    in_rec.insn      = in_insn;
    in_rec.trap      = in_trap;
    in_rec.halt      = in_halt;
    in_rec.rs1_addr  = in_rs1_addr;
    in_rec.rs2_addr  = in_rs2_addr;
    in_rec.rs1_rdata = in_rs1_rdata;
    in_rec.rs2_rdata = in_rs2_rdata;
    in_rec.rd_addr   = in_rd_addr;
    in_rec.rd_wdata  = in_rd_wdata;
    in_rec.pc_rdata  = in_pc_rdata;
    in_rec.pc_wdata  = in_pc_wdata;
    in_rec.mem_addr  = in_mem_addr;
    in_rec.mem_rmask = in_mem_rmask;
    in_rec.mem_wmask = in_mem_wmask;
    in_rec.mem_rdata = in_mem_rdata;
    in_rec.mem_wdata = in_mem_wdata;
    if (in_rd_addr == 5'd0) in_rec.rd_wdata = '0;
    if (in_trap) begin
      in_rec.rd_addr   = '0;
      in_rec.rd_wdata  = '0;
      in_rec.mem_wmask = '0;
      in_rec.mem_wdata = '0;
    end
  end

  // Storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= in_rec;
  end

`ifdef RVFI_RETIRE_INTR_EN
  logic            last_trap_q, last_trap_d;
  logic [XLEN-1:0] last_pc_wdata_q, last_pc_wdata_d;
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    halted_d    = halted_q;
    order_d     = order_q;
    out_order_d = out_order_q;
    out_d       = out_q;
    valid_d     = 1'b0;
    intr_d      = intr_q;
`ifdef RVFI_RETIRE_INTR_EN
    last_trap_d     = last_trap_q;
    last_pc_wdata_d = last_pc_wdata_q;
`endif
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      halted_d = halted_q | in_halt;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      out_d       = head;
      valid_d     = 1'b1;
      out_order_d = order_q;
      order_d     = order_q + 64'd1;
`ifdef RVFI_RETIRE_INTR_EN
      intr_d          = last_trap_q && (head.pc_rdata != last_pc_wdata_q);
      last_trap_d     = head.trap;
      last_pc_wdata_d = head.pc_wdata;
`else
      intr_d          = 1'b0;
`endif
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      halted_q    <= 1'b0;
      order_q     <= '0;
      out_order_q <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      intr_q      <= 1'b0;
`ifdef RVFI_RETIRE_INTR_EN
      last_trap_q     <= 1'b0;
      last_pc_wdata_q <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      halted_q    <= halted_d;
      order_q     <= order_d;
      out_order_q <= out_order_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      intr_q      <= intr_d;
`ifdef RVFI_RETIRE_INTR_EN
      last_trap_q     <= last_trap_d;
      last_pc_wdata_q <= last_pc_wdata_d;
`endif
    end
  end

  assign rvfi_valid     = valid_q;
  assign rvfi_order     = out_order_q;
  assign rvfi_intr      = intr_q;
  assign rvfi_insn      = out_q.insn;
  assign rvfi_trap      = out_q.trap;
  assign rvfi_halt      = out_q.halt;
  assign rvfi_rs1_addr  = out_q.rs1_addr;
  assign rvfi_rs2_addr  = out_q.rs2_addr;
  assign rvfi_rs1_rdata = out_q.rs1_rdata;
  assign rvfi_rs2_rdata = out_q.rs2_rdata;
  assign rvfi_rd_addr   = out_q.rd_addr;
  assign rvfi_rd_wdata  = out_q.rd_wdata;
  assign rvfi_pc_rdata  = out_q.pc_rdata;
  assign rvfi_pc_wdata  = out_q.pc_wdata;
  assign rvfi_mem_addr  = out_q.mem_addr;
  assign rvfi_mem_rmask = out_q.mem_rmask;
  assign rvfi_mem_wmask = out_q.mem_wmask;
  assign rvfi_mem_rdata = out_q.mem_rdata;
  assign rvfi_mem_wdata = out_q.mem_wdata;

endmodule
